// File: rtl/surf_cmd_pkg.sv
// surf_cmd_pkg: shared widths and FSM encoding for the SURF command path
package surf_cmd_pkg;
  localparam int NBUF = 4;
  localparam int BUF_W = 2;
  localparam int EVID_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
endpackage

// File: rtl/surf_buffer_scheduler_if.sv
// surf_buffer_scheduler_if: scheduler to SURF_command_interface_v3 handshake
interface surf_buffer_scheduler_if;
  import surf_cmd_pkg::*;
  logic cmd_start_o;
  logic [EVID_W-1:0] cmd_event_id_o;
  logic [BUF_W-1:0] cmd_buffer_o;
  logic cmd_busy_i;
  logic cmd_done_i;
  modport master(output cmd_start_o, cmd_event_id_o, cmd_buffer_o, input cmd_busy_i, cmd_done_i);
  modport slave(input cmd_start_o, cmd_event_id_o, cmd_buffer_o, output cmd_busy_i, cmd_done_i);
endinterface

// File: rtl/surf_rr_pick.sv
// surf_rr_pick: first free buffer at or after ptr, searching modulo NBUF
module surf_rr_pick
  import surf_cmd_pkg::*;
(
  input  logic [BUF_W-1:0] ptr,
  input  logic [NBUF-1:0]  free,
  output logic [BUF_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    valid = |free;
    for (int i = NBUF - 1; i >= 0; i--)
      if (free[ptr + BUF_W'(i)]) idx = ptr + BUF_W'(i);
  end
endmodule

// File: rtl/surf_buffer_scheduler.sv
// surf_buffer_scheduler: allocates SURF buffers to triggers and sequences the command link
module surf_buffer_scheduler
  import surf_cmd_pkg::*;
#(
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic [EVID_W-1:0]    trig_event_id_i,
  input  logic [NBUF-1:0]      release_i,
  surf_buffer_scheduler_if.master cmd,
  output logic [NBUF-1:0]      occupied_o,
  output logic                 full_o,
  output logic                 pending_o,
  output logic [15:0]          dropped_o,
  output logic                 err_o
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  state_t state;
  logic [BUF_W-1:0] ptr, pick;
  logic pick_ok, go, tmo_hit;
  logic [TW-1:0] tmo;
  logic [EVID_W-1:0] pend_id;
  surf_rr_pick u_pick (.ptr(ptr), .free(~occupied_o), .idx(pick), .valid(pick_ok));
  assign go = state == ST_IDLE && pending_o && pick_ok && !cmd.cmd_busy_i;
  assign tmo_hit = state == ST_WAIT && !cmd.cmd_done_i && tmo == '0;
  assign full_o = &occupied_o;
  // the issue edge does all slot/occupancy work so start, buffer and occupancy appear together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      ptr <= '0;
      tmo <= '0;
      pend_id <= '0;
      pending_o <= 1'b0;
      occupied_o <= '0;
      dropped_o <= '0;
      err_o <= 1'b0;
      cmd.cmd_start_o <= 1'b0;
      cmd.cmd_event_id_o <= '0;
      cmd.cmd_buffer_o <= '0;
    end else begin
      cmd.cmd_start_o <= go;
      occupied_o <= (occupied_o & ~release_i) | (go ? NBUF'(1) << pick : '0);
      err_o <= err_o | (|(release_i & ~occupied_o)) | tmo_hit;
      if (go) begin
        cmd.cmd_event_id_o <= pend_id;
        cmd.cmd_buffer_o <= pick;
        ptr <= pick + 1'b1;
      end
      if (trig_i && (!pending_o || go)) begin
        pending_o <= 1'b1;
        pend_id <= trig_event_id_i;
      end else if (go) pending_o <= 1'b0;
      if (trig_i && pending_o && !go && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
      case (state)
        ST_IDLE: state <= go ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: begin
          state <= ST_WAIT;
          tmo <= TW'(DONE_TIMEOUT - 1);
        end
        ST_WAIT: begin
          state <= (cmd.cmd_done_i || tmo_hit) ? ST_IDLE : ST_WAIT;
          tmo <= tmo - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
